dcache_miss_ctrl: RTL



---
 rtl/cache_axi_pkg.sv | 28 ++
 rtl/line_beat_buf.sv | 39 +++
 rtl/dcache_miss_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the data-cache miss path: FSM states,
// line geometry and the fixed AXI burst encoding used for line transfers.
package cache_axi_pkg;

    localparam int LINE_W = 128;
    localparam int BEATS  = LINE_W / 32;
    localparam int CNT_W  = $clog2(BEATS);

    localparam logic [7:0] AXI_LEN   = 8'(BEATS - 1);
    localparam logic [2:0] AXI_SIZE  = 3'b010;
    localparam logic [1:0] AXI_BURST = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_RD,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_REFILL
    } state_t;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFF0;
    endfunction

endpackage

// File: rtl/line_beat_buf.sv
// One cache line held as 32-bit beats with a beat counter; loaded whole and
// walked out for a write burst, or filled beat by beat from a read burst.
module line_beat_buf
    import cache_axi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_wr,
    input  logic [31:0]       i_wdata,
    input  logic              i_adv,
    output logic [LINE_W-1:0] o_line,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [BEATS-1:0][31:0] r_line;
    logic [CNT_W-1:0]       r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_line <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_line <= i_line;
            r_cnt  <= '0;
        end else if (i_wr) begin
            r_line[r_cnt] <= i_wdata;
            r_cnt         <= r_cnt + CNT_W'(1);
        end else if (i_adv) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_line = r_line;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss handler: optional dirty-victim write-back over AXI, then a
// line fetch over AXI and a single-cycle refill into the chosen way.
module dcache_miss_ctrl
    import cache_axi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    output logic              miss_ready,
    input  logic [31:0]       miss_addr,
    input  logic              miss_way,
    input  logic              miss_dirty,
    input  logic [31:0]       victim_addr,
    output logic              miss_done,
    output logic              wb_ena,
    output logic [31:0]       wb_addr,
    output logic              wb_way,
    input  logic [LINE_W-1:0] wb_DCache_line,
    output logic              DCache_Wena,
    output logic              update_way,
    output logic [31:0]       update_addr,
    output logic [LINE_W-1:0] update_DCache_line,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_t      r_state;
    logic        r_miss_ready, r_wb_ena, r_awvalid, r_wvalid, r_bready;
    logic        r_arvalid, r_rready, r_wena, r_done, r_way;
    logic [31:0] r_line_addr, r_victim_addr;

    logic              w_acc, w_w_hs, w_r_hs, w_r_end;
    logic [LINE_W-1:0] w_wbuf_line, w_rbuf_line;
    logic [CNT_W-1:0]  w_wcnt, w_rcnt;

    assign w_acc   = (r_state == S_IDLE) && miss_req;
    assign w_w_hs  = r_wvalid && wready;
    assign w_r_hs  = r_rready && rvalid;
    // rlast ends the fetch even if the slave sends a short burst
    assign w_r_end = rlast || (w_rcnt == CNT_W'(BEATS - 1));

    line_beat_buf u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_load  (r_state == S_WB_RD),
        .i_line  (wb_DCache_line),
        .i_wr    (1'b0),
        .i_wdata (32'd0),
        .i_adv   (w_w_hs),
        .o_line  (w_wbuf_line),
        .o_cnt   (w_wcnt)
    );

    line_beat_buf u_rbuf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_acc),
        .i_load  (1'b0),
        .i_line  ('0),
        .i_wr    (w_r_hs),
        .i_wdata (rdata),
        .i_adv   (1'b0),
        .o_line  (w_rbuf_line),
        .o_cnt   (w_rcnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_miss_ready  <= 1'b1;
            r_wb_ena      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_wena        <= 1'b0;
            r_done        <= 1'b0;
            r_way         <= 1'b0;
            r_line_addr   <= '0;
            r_victim_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (miss_req) begin
                    r_line_addr   <= line_addr(miss_addr);
                    r_victim_addr <= line_addr(victim_addr);
                    r_way         <= miss_way;
                    r_miss_ready  <= 1'b0;
                    if (miss_dirty) begin
                        r_wb_ena <= 1'b1;
                        r_state  <= S_WB_RD;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end
                end
                S_WB_RD: begin
                    r_wb_ena  <= 1'b0;
                    r_awvalid <= 1'b1;
                    r_state   <= S_AW;
                end
                S_AW: if (awready) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b1;
                    r_state   <= S_W;
                end
                S_W: if (w_w_hs && (w_wcnt == CNT_W'(BEATS - 1))) begin
                    r_wvalid <= 1'b0;
                    r_bready <= 1'b1;
                    r_state  <= S_B;
                end
                S_B: if (bvalid) begin
                    r_bready  <= 1'b0;
                    r_arvalid <= 1'b1;
                    r_state   <= S_AR;
                end
                S_AR: if (arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= S_R;
                end
                S_R: if (w_r_hs && w_r_end) begin
                    r_rready <= 1'b0;
                    r_wena   <= 1'b1;
                    r_done   <= 1'b1;
                    r_state  <= S_REFILL;
                end
                S_REFILL: begin
                    r_wena       <= 1'b0;
                    r_done       <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign miss_ready         = r_miss_ready;
    assign miss_done          = r_done;
    assign wb_ena             = r_wb_ena;
    assign wb_addr            = r_victim_addr;
    assign wb_way             = r_way;
    assign DCache_Wena        = r_wena;
    assign update_way         = r_way;
    assign update_addr        = r_line_addr;
    assign update_DCache_line = w_rbuf_line;

    // burst attributes read as zero whenever their channel is idle
    assign araddr  = r_line_addr;
    assign arlen   = r_arvalid ? AXI_LEN   : 8'd0;
    assign arsize  = r_arvalid ? AXI_SIZE  : 3'd0;
    assign arburst = r_arvalid ? AXI_BURST : 2'd0;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awaddr  = r_victim_addr;
    assign awlen   = r_awvalid ? AXI_LEN   : 8'd0;
    assign awsize  = r_awvalid ? AXI_SIZE  : 3'd0;
    assign awburst = r_awvalid ? AXI_BURST : 2'd0;
    assign awvalid = r_awvalid;

    assign wdata  = w_wbuf_line[{w_wcnt, 5'd0} +: 32];
    assign wstrb  = r_wvalid ? 4'hF : 4'h0;
    assign wlast  = r_wvalid && (w_wcnt == CNT_W'(BEATS - 1));
    assign wvalid = r_wvalid;
    assign bready = r_bready;

endmodule
